// File: rtl/mar_program_loader.sv
// SAP-1 MAR stage with a program-mode RAM write sequencer.
// Each accepted word is written with a setup/write/recover strobe sequence.
module mar_program_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              CLR_bar,
    input  logic              L_M_bar,
    input  logic [ADDR_W-1:0] bus_input,
    input  logic              run_or_prog,
    input  logic              auto_inc,
    input  logic [ADDR_W-1:0] program_address,
    input  logic [DATA_W-1:0] program_data,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic              ptr_clear,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_WE_bar,
    output logic              mode,
    output logic              ptr_wrap
);

    typedef enum logic [1:0] {StIdle, StSetup, StWrite, StRecover} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] mar_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] ram_data_q;
    logic              mode_q;
    logic              we_bar_q;
    logic              wrap_q;
    logic              inc_q;
    logic              accept;
    logic              ptr_step;

    assign prog_ready = (state_q == StIdle) && !mode_q;
    assign accept     = prog_valid && prog_ready;
    // Pointer advances only when a word taken with auto_inc leaves WRITE.
    assign ptr_step   = (state_q == StWrite) && inc_q;

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            mar_q <= '0;
        end else if (!L_M_bar) begin
            mar_q <= bus_input;
        end
    end

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            state_q    <= StIdle;
            mode_q     <= 1'b1;
            we_bar_q   <= 1'b1;
            wr_addr_q  <= '0;
            ram_data_q <= '0;
            inc_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    mode_q <= run_or_prog;
                    if (accept) begin
                        wr_addr_q  <= auto_inc ? ptr_q : program_address;
                        ram_data_q <= program_data;
                        inc_q      <= auto_inc;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    we_bar_q <= 1'b0;
                    state_q  <= StWrite;
                end
                StWrite: begin
                    we_bar_q <= 1'b1;
                    state_q  <= StRecover;
                end
                StRecover: begin
                    state_q <= StIdle;
                end
                default: begin
                    we_bar_q <= 1'b1;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else if (ptr_clear) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else if (ptr_step) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            if (&ptr_q) begin
                wrap_q <= 1'b1;
            end
        end
    end

    always_comb begin
        address = mar_q;
        if (!mode_q) begin
            if (state_q != StIdle) begin
                address = wr_addr_q;
            end else begin
                address = auto_inc ? ptr_q : program_address;
            end
        end
    end

    assign ram_data   = ram_data_q;
    assign ram_WE_bar = we_bar_q;
    assign mode       = mode_q;
    assign ptr_wrap   = wrap_q;

endmodule
